// File: rtl/irq_pending_encoder_pkg.sv
// Shared constants and FSM state type for the IRQ pending encoder.
package irq_enc_pkg;

    localparam int N = 16;
    localparam int W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

endpackage

// File: rtl/irq_pending_encoder_if.sv
// Valid/ready handshake carrying the offered interrupt code.
interface irq_pending_encoder_if;
    import irq_enc_pkg::*;

    logic [W-1:0] y;
    logic         valid;
    logic         ready;

    modport master (output y, output valid, input ready);
    modport slave  (input y, input valid, output ready);

endinterface

// File: rtl/irq_pending_encoder_priority_enc16.sv
// Combinational 16-to-4 priority encoder: highest set index wins.
module priority_enc16
    import irq_enc_pkg::*;
(
    input  logic [N-1:0] req_vec,
    output logic [W-1:0] y,
    output logic         any
);

    // Ascending scan so the last (highest) set index overrides lower ones
    always_comb begin
        y = {W{1'b0}};
        for (int k = 0; k < N; k++) begin
            y = req_vec[k] ? W'(k) : y;
        end
        any = |req_vec;
    end

endmodule

// File: rtl/irq_pending_encoder.sv
// Captures request rising edges into a pending register and offers the
// highest unmasked pending index over a valid/ready handshake.
module irq_pending_encoder
    import irq_enc_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N-1:0]          i,
    input  logic [N-1:0]          mask,
    irq_pending_encoder_if.master bus,
    output logic [N-1:0]          pending,
    output logic                  overflow
);

    logic [N-1:0] i_q_r;
    logic [N-1:0] pending_r;
    logic [N-1:0] rise_s;
    logic [N-1:0] clr_s;
    logic [N-1:0] cand_s;
    logic [W-1:0] win_s;
    logic [W-1:0] y_r;
    logic         any_s;
    logic         valid_r;
    logic         overflow_r;
    logic         accept_s;
    state_t       state_r;

    priority_enc16 u_prio (
        .req_vec (cand_s),
        .y       (win_s),
        .any     (any_s)
    );

    // Edge detect, one-hot clear of the accepted code, and selection candidates
    always_comb begin
        rise_s   = i & ~i_q_r;
        accept_s = (state_r == OFFER) && bus.ready;
        if (accept_s) begin
            clr_s = {{(N-1){1'b0}}, 1'b1} << y_r;
        end else begin
            clr_s = {N{1'b0}};
        end
        cand_s   = pending_r & ~mask;
    end

    // Pending/overflow bookkeeping and the IDLE/OFFER handshake FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q_r      <= {N{1'b0}};
            pending_r  <= {N{1'b0}};
            overflow_r <= 1'b0;
            y_r        <= {W{1'b0}};
            valid_r    <= 1'b0;
            state_r    <= IDLE;
        end else begin
            i_q_r      <= i;
            // A new rise re-sets a bit even when it is cleared by acceptance
            pending_r  <= (pending_r & ~clr_s) | rise_s;
            overflow_r <= |(rise_s & pending_r & ~clr_s);
            case (state_r)
                IDLE: begin
                    if (en && any_s) begin
                        y_r     <= win_s;
                        valid_r <= 1'b1;
                        state_r <= OFFER;
                    end else begin
                        valid_r <= 1'b0;
                    end
                end
                OFFER: begin
                    if (bus.ready) begin
                        valid_r <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.y     = y_r;
    assign bus.valid = valid_r;
    assign pending   = pending_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_irq_pending_encoder.sv
// Self-checking bench: directed tables/sequences plus random traffic vs. a reference model.
module tb_irq_pending_encoder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [15:0] req;
    logic [15:0] msk;
    logic [15:0] pending;
    logic        overflow;

    irq_pending_encoder_if bus ();

    irq_pending_encoder dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .i        (req),
        .mask     (msk),
        .bus      (bus),
        .pending  (pending),
        .overflow (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model state: one entry per request line
    bit m_prev [16];
    bit m_pend [16];
    bit m_valid;
    int m_y;
    bit m_ovf;

    int acc_q [$];

    typedef struct {
        logic [15:0] req;
        logic [15:0] msk;
        logic        ena;
        logic        rdy;
        logic        exp_valid;
        logic [3:0]  exp_y;
        logic [15:0] exp_pend;
        logic        exp_ovf;
    } vec_t;

    vec_t tv [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 16; k++) begin
            m_prev[k] = 1'b0;
            m_pend[k] = 1'b0;
        end
        m_valid = 1'b0;
        m_y     = 0;
        m_ovf   = 1'b0;
    endfunction

    function automatic logic [15:0] m_pend_vec();
        logic [15:0] v;
        v = 16'h0000;
        for (int k = 0; k < 16; k++) v[k] = m_pend[k];
        return v;
    endfunction

    // One clock edge of the behavioural model, from the current inputs
    function automatic void model_edge();
        bit acc;
        int win;
        bit np [16];
        bit ovf;
        acc = m_valid && bus.ready;
        win = -1;
        for (int k = 15; k >= 0; k--) begin
            if (win < 0 && m_pend[k] && !msk[k]) win = k;
        end
        ovf = 1'b0;
        for (int k = 0; k < 16; k++) begin
            bit rise;
            bit clr;
            rise = req[k] && !m_prev[k];
            clr  = acc && (k == m_y);
            if (rise && m_pend[k] && !clr) ovf = 1'b1;
            np[k] = (m_pend[k] && !clr) || rise;
        end
        if (!m_valid) begin
            if (en && win >= 0) begin
                m_valid = 1'b1;
                m_y     = win;
            end
        end else if (bus.ready) begin
            m_valid = 1'b0;
        end
        for (int k = 0; k < 16; k++) begin
            m_pend[k] = np[k];
            m_prev[k] = req[k];
        end
        m_ovf = ovf;
    endfunction

    task automatic cmp_model();
        check("model_valid", 32'(bus.valid), 32'(m_valid));
        if (m_valid) check("model_y", 32'(bus.y), 32'(m_y));
        check("model_pending", 32'(pending), 32'(m_pend_vec()));
        check("model_overflow", 32'(overflow), 32'(m_ovf));
    endtask

    // Advance one clock: log any acceptance, update model, compare at negedge
    task automatic step();
        if (bus.valid && bus.ready) acc_q.push_back(int'(bus.y));
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        @(negedge clk);
        cmp_model();
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 16'h0000; msk = 16'h0000; bus.ready = 1'b0;
        model_reset();

        // Reset state and first event after release
        repeat (2) @(negedge clk);
        check("rst_y", 32'(bus.y), 32'd0);
        check("rst_valid", 32'(bus.valid), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        req = 16'h0004; rst = 1'b0;
        step();
        check("first_pending", 32'(pending), 32'h0004);
        step();
        check("first_valid", 32'(bus.valid), 32'd1);
        check("first_y", 32'(bus.y), 32'd2);
        rst = 1'b1; req = 16'h0000;
        step();
        rst = 1'b0;

        // Priority table: lines 3, 9, 15 together, drained one by one
        tv[0] = '{16'h8208, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  16'h8208, 1'b0};
        for (int r = 1; r <= 5; r++)
            tv[r] = '{16'h8208, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd15, 16'h8208, 1'b0};
        tv[6]  = '{16'h8208, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd15, 16'h0208, 1'b0};
        tv[7]  = '{16'h8208, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd9,  16'h0208, 1'b0};
        tv[8]  = '{16'h8208, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd9,  16'h0008, 1'b0};
        tv[9]  = '{16'h8208, 16'h0000, 1'b1, 1'b0, 1'b1, 4'd3,  16'h0008, 1'b0};
        tv[10] = '{16'h8208, 16'h0000, 1'b1, 1'b1, 1'b0, 4'd3,  16'h0000, 1'b0};
        tv[11] = '{16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 4'd0,  16'h0000, 1'b0};
        for (int r = 0; r < 12; r++) begin
            req = tv[r].req; msk = tv[r].msk; en = tv[r].ena; bus.ready = tv[r].rdy;
            step();
            check("tbl_valid", 32'(bus.valid), 32'(tv[r].exp_valid));
            if (tv[r].exp_valid) check("tbl_y", 32'(bus.y), 32'(tv[r].exp_y));
            check("tbl_pending", 32'(pending), 32'(tv[r].exp_pend));
            check("tbl_overflow", 32'(overflow), 32'(tv[r].exp_ovf));
        end

        // Shift sweep: one code per 3 cycles, delivered in order
        acc_q.delete();
        bus.ready = 1'b1;
        for (int s = 0; s < 10; s++) begin
            req = 16'h0001 << s;
            repeat (3) step();
        end
        check("sweep_count", 32'(acc_q.size()), 32'd10);
        for (int s = 0; s < 10 && s < acc_q.size(); s++) check("sweep_code", 32'(acc_q[s]), 32'(s));
        check("sweep_pending", 32'(pending), 32'd0);

        // Mask: 15 masked so 7 goes first; masking 7 mid-offer changes nothing
        req = 16'h0000; bus.ready = 1'b0;
        step();
        req = 16'h8080; msk = 16'h8000;
        step();
        step();
        check("mask_first_y", 32'(bus.y), 32'd7);
        msk = 16'h0080;
        step();
        check("mask_hold_valid", 32'(bus.valid), 32'd1);
        check("mask_hold_y", 32'(bus.y), 32'd7);
        msk = 16'h0000; bus.ready = 1'b1;
        step();
        bus.ready = 1'b0;
        step();
        check("mask_next_y", 32'(bus.y), 32'd15);
        en = 1'b0;
        step();
        check("en_drop_valid", 32'(bus.valid), 32'd1);
        check("en_drop_y", 32'(bus.y), 32'd15);
        en = 1'b1; bus.ready = 1'b1;
        step();
        check("mask_drained", 32'(pending), 32'd0);
        bus.ready = 1'b0; req = 16'h0000;
        step();

        // Overflow pulse, then rise colliding with acceptance
        en = 1'b0; req = 16'h0020;
        step();
        req = 16'h0000;
        step();
        req = 16'h0020;
        step();
        check("ovf_pulse", 32'(overflow), 32'd1);
        step();
        check("ovf_one_cycle", 32'(overflow), 32'd0);
        en = 1'b1;
        step();
        check("coll_offer_y", 32'(bus.y), 32'd5);
        req = 16'h0000;
        step();
        req = 16'h0020; bus.ready = 1'b1;
        step();
        check("coll_pending5", 32'(pending[5]), 32'd1);
        check("coll_overflow", 32'(overflow), 32'd0);
        check("coll_valid", 32'(bus.valid), 32'd0);
        bus.ready = 1'b0;
        step();
        check("reoffer_valid", 32'(bus.valid), 32'd1);

        // Asynchronous reset between edges while offering
        #2;
        rst = 1'b1; req = 16'h0000;
        #1;
        check("arst_valid", 32'(bus.valid), 32'd0);
        check("arst_pending", 32'(pending), 32'd0);
        model_reset();
        step();
        #2 rst = 1'b0;
        repeat (4) begin
            step();
            check("arst_no_offer", 32'(bus.valid), 32'd0);
        end

        // Randomised traffic against the model
        for (int n = 0; n < 400; n++) begin
            req = req ^ (16'($urandom) & 16'($urandom) & 16'($urandom));
            msk = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
            en = ($urandom_range(0, 7) != 0);
            bus.ready = ($urandom_range(0, 1) == 1);
            rst = ($urandom_range(0, 149) == 0);
            step();
        end
        rst = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/irq_pending_encoder.md
# irq_pending_encoder

Registered request front-end feeding the 16-to-4 encoder stage. Captures rising edges on 16 request lines into a pending register, applies a mask, selects the highest-index unmasked pending line, and presents its 4-bit code on a valid/ready handshake. The consumer's acceptance clears the serviced pending bit. This block is the sequential stage directly upstream of code consumers in the encoder path.

## Interface
- `N`, default 16: number of request lines; fixed at 16 for this release.
- `W`, default 4: code width, equal to log2(N).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `en`  in  1  arbitration enable; when low, no new offer is started.
- `i`  in  N  raw request lines, synchronous to `clk`.
- `mask`  in  N  1 = line excluded from selection; its pending bit is still recorded.
- `y`  out  W  offered code, the index of the selected line.
- `valid`  out  1  `y` is being offered.
- `ready`  in  1  consumer accepts `y` when `valid` and `ready` are both high at a clock edge.
- `pending`  out  N  current pending register.
- `overflow`  out  1  one-cycle pulse when a rising edge is seen on a line whose pending bit is already set.

## Operation
- Edge detect: `i_q` is `i` delayed by one register; `rise = i & ~i_q`.
- `pending_next = (pending & ~clr) | rise`. `clr` is one-hot at index `y` in the cycle where `valid && ready`, and 0 otherwise. A set wins over a clear on the same bit.
- Candidate set is `pending & ~mask`. The winner is the highest set index; `any` is the OR of the candidate set.
- FSM has 2 states:
  - IDLE: `valid` = 0. If `en && any`, register `y` = winner index, set `valid` = 1, and go to OFFER.
  - OFFER: `valid` = 1 and `y` is held stable regardless of `i`, `mask`, `en`, or new pending bits. On `ready`, clear `pending[y]`, set `valid` = 0, and go to IDLE.
- Throughput is at most 1 code per 2 cycles, because there is a mandatory IDLE bubble.
- Overflow: `overflow` is registered and equals `|(rise & pending & ~clr)`.
- Reset values: `y` = 0, `valid` = 0, `pending` = 0, `overflow` = 0, `i_q` = 0, FSM = IDLE.
  - Because `i_q` resets to 0, a line held high through reset produces an event on the first edge after reset.

## Timing
- Request to offer: `i[k]` rises before edge E0. `pending[k]` = 1 after E0. `valid` = 1 with `y` = k after E1, if `k` wins, `en` = 1, and the FSM is in IDLE at E1.
- Acceptance at edge Ea clears `pending[y]` and drops `valid` after Ea. The next offer appears no earlier than Ea+1.
- `ready` while `valid` = 0 is ignored.
- Masking a line during OFFER does not retract the offer; the code is still delivered and cleared.
- Dropping `en` during OFFER does not abort the offer.
- Simultaneous rise on `y` and acceptance: the bit stays pending and no overflow is reported.
- Simultaneous rises on multiple lines are all recorded in the same cycle.
- `rst` asserted at any point, including OFFER: all state clears immediately and asynchronously. A pending offer is lost.

## Structure
- Package `irq_enc_pkg`:
  - constants `N` = 16 and `W` = 4;
  - state enum `{IDLE, OFFER}`.
- Sub-module `priority_enc16`: purely combinational. Takes a 16-bit input, returns `y[3:0]` (highest set index) and `any`. It is instantiated once on `pending & ~mask`.
- The top level holds `i_q`, `pending`, the FSM, the output registers, and overflow.

## Test plan
- Reset: hold `rst` = 1 with `i` = 16'h0000. Required: `y` = 0, `valid` = 0, `pending` = 0, `overflow` = 0. Then release `rst` with `i` = 16'h0004. Required: `pending` = 16'h0004 after the 1st edge; `valid` = 1 with `y` = 2 after the 2nd edge.
- Shift sweep: start `i` = 16'h0001, shift left once every 3 cycles for 9 steps, `ready` = 1. Required: codes 0,1,2,…,9 each delivered once in order, and `pending` = 0 at the end.
- Priority: with `ready` = 0, make lines 3, 9 and 15 rise together. Required: `y` = 15 held with `valid` for 5 cycles. Then pulse `ready`. Required: next offer `y` = 9, then `y` = 3.
- Mask: `mask` = 16'h8000 and rises on lines 15 and 7. Required: `y` = 7 offered first. Clear the mask. Required: `y` = 15 offered next. Setting the mask mid-offer must not change `y`.
- Overflow and collision: line 5 pending, drop `i[5]` then re-raise it. Required: `overflow` pulses for 1 cycle. Re-raise `i[5]` in the same cycle as acceptance of `y` = 5. Required: `pending[5]` stays 1 and `overflow` = 0.
- Reset mid-offer: assert `rst` asynchronously, between edges, while `valid` = 1. Required: `valid` = 0 and `pending` = 0 immediately, and no offer after release until a new rise.
